gamma_pwm: RTL and testbench

- Multi-channel LED driver: per-channel gamma correction through a run-time loadable lookup table, feeding glitch-free PWM outputs.
- Sits between colour/animation logic and the LED pins.
- The table is initialised to a linear (identity) curve at reset; firmware or a loader block then writes the gamma curve.
- Duty updates are double-buffered and take effect only at PWM period boundaries.

---
 rtl/gamma_pwm_if.sv | 25 ++
 rtl/gamma_pwm.sv | 153 +++++++++++++++
 tb/tb_gamma_pwm.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/gamma_pwm_if.sv
// Value and LUT-load port bundle for gamma_pwm.
// The master side is the colour/animation logic; the slave side is the LED driver.
interface gamma_pwm_if #(
    parameter int CHANNELS  = 3,
    parameter int IN_WIDTH  = 8,
    parameter int OUT_WIDTH = 8
);
    logic [CHANNELS*IN_WIDTH-1:0] value_in;
    logic                         value_valid;
    logic                         value_ready;
    logic                         lut_we;
    logic [IN_WIDTH-1:0]          lut_addr;
    logic [OUT_WIDTH-1:0]         lut_wdata;
    logic                         lut_ready;

    modport master (
        output value_in, value_valid, lut_we, lut_addr, lut_wdata,
        input  value_ready, lut_ready
    );

    modport slave (
        input  value_in, value_valid, lut_we, lut_addr, lut_wdata,
        output value_ready, lut_ready
    );
endinterface

// File: rtl/gamma_pwm.sv
// Multi-channel LED driver: run-time loadable gamma LUT feeding glitch-free PWM.
// Duty updates are double-buffered and only take effect at PWM period boundaries.
module gamma_pwm #(
    parameter int CHANNELS  = 3,
    parameter int IN_WIDTH  = 8,
    parameter int OUT_WIDTH = 8,
    parameter int PRESCALE  = 1
) (
    input  logic                clk,
    input  logic                rst,
    gamma_pwm_if.slave          bus,
    output logic                busy,
    output logic                period_start,
    output logic [CHANNELS-1:0] pwm_out
);
    localparam int DEPTH  = 1 << IN_WIDTH;
    localparam int PSC_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int LK_W   = $clog2(CHANNELS + 1);
    localparam int PEND_W = CHANNELS * OUT_WIDTH;
    localparam logic [PSC_W-1:0]     PSC_LAST = PSC_W'(PRESCALE - 1);
    localparam logic [OUT_WIDTH-1:0] CNT_LAST = {{(OUT_WIDTH-1){1'b1}}, 1'b0};
    localparam logic [LK_W-1:0]      LK_LAST  = LK_W'(CHANNELS);

    typedef enum logic [1:0] {INIT, IDLE, LOOKUP} state_t;

    state_t                       state;
    logic [IN_WIDTH-1:0]          init_idx;
    logic [LK_W-1:0]              lk;
    logic [CHANNELS*IN_WIDTH-1:0] shadow;
    logic [PEND_W-1:0]            pending;
    logic [PEND_W-1:0]            active;
    logic                         pending_valid;
    logic [PSC_W-1:0]             psc;
    logic [OUT_WIDTH-1:0]         cnt;

    logic [OUT_WIDTH-1:0] mem [DEPTH];
    logic [OUT_WIDTH-1:0] rd_data;
    logic [OUT_WIDTH-1:0] init_data;
    logic [OUT_WIDTH-1:0] ram_wdata;
    logic [IN_WIDTH-1:0]  ram_addr;
    logic                 ram_we;
    logic                 tick;
    logic                 wrap;

    // Identity curve: scale the index to the output width.
    generate
        if (OUT_WIDTH >= IN_WIDTH) begin : g_scale_up
            assign init_data = OUT_WIDTH'(init_idx) << (OUT_WIDTH - IN_WIDTH);
        end else begin : g_scale_down
            assign init_data = OUT_WIDTH'(init_idx >> (IN_WIDTH - OUT_WIDTH));
        end
    endgenerate

    // Single RAM port shared by INIT fill, IDLE writes and LOOKUP reads.
    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        ram_we    = 1'b0;
        ram_addr  = shadow[IN_WIDTH-1:0];
        ram_wdata = bus.lut_wdata;
        if (!rst) begin
            case (state)
                INIT: begin
                    ram_we    = 1'b1;
                    ram_addr  = init_idx;
                    ram_wdata = init_data;
                end
                IDLE: begin
                    ram_we   = bus.lut_we;
                    ram_addr = bus.lut_addr;
                end
                default: ;
            endcase
        end
    end

    // NOTE: the table has no reset branch; INIT rewrites every entry instead.
    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        rd_data <= mem[ram_addr];
    end

    assign tick = (psc == PSC_LAST);
    assign wrap = tick && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= INIT;
            init_idx        <= '0;
            lk              <= '0;
            shadow          <= '0;
            pending         <= '0;
            active          <= '0;
            pending_valid   <= 1'b0;
            psc             <= '0;
            cnt             <= '0;
            period_start    <= 1'b0;
            pwm_out         <= '0;
            busy            <= 1'b1;
            bus.value_ready <= 1'b0;
            bus.lut_ready   <= 1'b0;
        end else begin
            psc          <= tick ? '0 : psc + 1'b1;
            period_start <= wrap;
            if (tick) cnt <= wrap ? '0 : cnt + 1'b1;
            if (wrap && pending_valid) begin
                active        <= pending;
                pending_valid <= 1'b0;
            end
            for (int c = 0; c < CHANNELS; c++)
                pwm_out[c] <= (cnt < active[c*OUT_WIDTH +: OUT_WIDTH]);

            case (state)
                INIT: begin
                    init_idx <= init_idx + 1'b1;
                    if (init_idx == '1) begin
                        state           <= IDLE;
                        busy            <= 1'b0;
                        bus.value_ready <= 1'b1;
                        bus.lut_ready   <= 1'b1;
                    end
                end
                IDLE: begin
                    if (bus.value_valid) begin
                        shadow          <= bus.value_in;
                        pending_valid   <= 1'b0;
                        lk              <= '0;
                        state           <= LOOKUP;
                        busy            <= 1'b1;
                        bus.value_ready <= 1'b0;
                        bus.lut_ready   <= 1'b0;
                    end
                end
                LOOKUP: begin
                    // Channel k is read in cycle k; its data is shifted in from the top one cycle later.
                    shadow <= shadow >> IN_WIDTH;
                    if (lk != '0)
                        pending <= (pending >> OUT_WIDTH)
                                 | (PEND_W'(rd_data) << ((CHANNELS - 1) * OUT_WIDTH));
                    if (lk == LK_LAST) begin
                        pending_valid   <= 1'b1;
                        state           <= IDLE;
                        busy            <= 1'b0;
                        bus.value_ready <= 1'b1;
                        bus.lut_ready   <= 1'b1;
                    end else begin
                        lk <= lk + 1'b1;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_gamma_pwm.sv
// Directed bench for gamma_pwm: 3 channels, 8-bit in/out, PRESCALE=1 (period 255 clks).
// Outputs are sampled on the falling edge; inputs are driven on the falling edge.
module tb_gamma_pwm;
    logic       clk = 1'b0;
    logic       rst;
    logic       busy;
    logic       period_start;
    logic [2:0] pwm_out;

    int checks = 0;
    int errors = 0;

    gamma_pwm_if #(.CHANNELS(3), .IN_WIDTH(8), .OUT_WIDTH(8)) bus ();

    gamma_pwm #(.CHANNELS(3), .IN_WIDTH(8), .OUT_WIDTH(8), .PRESCALE(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .busy         (busy),
        .period_start (period_start),
        .pwm_out      (pwm_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Counts falling edges with busy high, starting at the current one.
    task automatic init_len(input string tag);
        int n = 0;
        while (busy === 1'b1 && n < 1000) begin
            n++;
            @(negedge clk);
        end
        check(tag, n, 256);
    endtask

    task automatic send(input logic [23:0] v);
        int n = 0;
        while (bus.value_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", bus.value_ready, 1);
        bus.value_in    = v;
        bus.value_valid = 1'b1;
        @(negedge clk);
        bus.value_valid = 1'b0;
    endtask

    task automatic wait_ps(input string tag);
        int n = 0;
        while (period_start !== 1'b1 && n < 600) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ps_seen"}, period_start, 1);
    endtask

    // Called on the edge showing period_start: counts high cycles over one full period.
    task automatic measure(input string tag, input int e0, input int e1, input int e2);
        int h0 = 0;
        int h1 = 0;
        int h2 = 0;
        for (int i = 0; i < 255; i++) begin
            @(negedge clk);
            h0 += int'(pwm_out[0]);
            h1 += int'(pwm_out[1]);
            h2 += int'(pwm_out[2]);
        end
        check({tag, "_ch0"}, h0, e0);
        check({tag, "_ch1"}, h1, e1);
        check({tag, "_ch2"}, h2, e2);
        check({tag, "_period"}, period_start, 1);
    endtask

    initial begin
        rst             = 1'b1;
        bus.value_in    = '0;
        bus.value_valid = 1'b0;
        bus.lut_we      = 1'b0;
        bus.lut_addr    = '0;
        bus.lut_wdata   = '0;
        repeat (3) @(negedge clk);

        check("rst_busy", busy, 1);
        check("rst_value_ready", bus.value_ready, 0);
        check("rst_lut_ready", bus.lut_ready, 0);
        check("rst_pwm", pwm_out, 0);
        check("rst_period_start", period_start, 0);

        // 1: identity table after INIT
        rst = 1'b0;
        init_len("init_len");
        check("idle_value_ready", bus.value_ready, 1);
        check("idle_lut_ready", bus.lut_ready, 1);
        check("idle_busy", busy, 0);
        send({8'd255, 8'd100, 8'd0});
        repeat (6) @(negedge clk);
        wait_ps("t1");
        measure("t1", 0, 100, 255);

        // 2: full, half and zero duty
        send({8'd0, 8'd128, 8'd255});
        repeat (6) @(negedge clk);
        wait_ps("t2");
        measure("t2", 255, 128, 0);

        // 3: LUT rewrite; old duty held until the boundary
        bus.lut_we    = 1'b1;
        bus.lut_addr  = 8'd128;
        bus.lut_wdata = 8'd37;
        @(negedge clk);
        bus.lut_we = 1'b0;
        send({8'd0, 8'd128, 8'd255});
        repeat (90) @(negedge clk);
        check("t3_hold", pwm_out[1], 1);
        wait_ps("t3");
        measure("t3", 255, 37, 0);

        // 4: set A superseded by set B before the wrap
        send({8'd30, 8'd20, 8'd10});
        send({8'd80, 8'd70, 8'd60});
        repeat (20) @(negedge clk);
        check("t4_hold", pwm_out, 3'b011);
        wait_ps("t4");
        measure("t4", 60, 70, 80);

        // 5: LUT write and value accept in the same IDLE cycle
        bus.lut_we      = 1'b1;
        bus.lut_addr    = 8'd5;
        bus.lut_wdata   = 8'd200;
        bus.value_in    = {8'd5, 8'd5, 8'd5};
        bus.value_valid = 1'b1;
        @(negedge clk);
        bus.lut_we      = 1'b0;
        bus.value_valid = 1'b0;
        repeat (6) @(negedge clk);
        wait_ps("t5");
        measure("t5", 200, 200, 200);

        // 6: reset mid-LOOKUP and mid-period
        repeat (50) @(negedge clk);
        send({8'd5, 8'd5, 8'd5});
        check("t6_pre_busy", busy, 1);
        check("t6_pre_pwm", pwm_out, 3'b111);
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_pwm", pwm_out, 0);
        check("t6_rst_busy", busy, 1);
        check("t6_rst_period_start", period_start, 0);
        check("t6_rst_value_ready", bus.value_ready, 0);
        rst = 1'b0;
        init_len("t6_init_len");
        send({8'd255, 8'd128, 8'd5});
        repeat (6) @(negedge clk);
        wait_ps("t6");
        measure("t6", 5, 128, 255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
